// File: rtl/pn_sort_pipe.sv
// Pipelined compare-and-swap permutation network for the deflection path.
// Winner (smallest key) exits on port 0; global stall, alternating tie-break, swap statistic.
module pn_sort_pipe #(
  parameter int NUM_PORTS  = 4,
  parameter int WIDTH_TIME = 8,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_CNT  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             stall,
  input  logic                             clr_stats,
  input  logic [NUM_PORTS*WIDTH_TIME-1:0]  in_time,
  input  logic [NUM_PORTS*WIDTH_DATA-1:0]  in_data,
  output logic [NUM_PORTS*WIDTH_TIME-1:0]  out_time,
  output logic [NUM_PORTS*WIDTH_DATA-1:0]  out_data,
  output logic                             mode,
  output logic [WIDTH_CNT-1:0]             swap_cnt
);

  localparam int S  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int SW = WIDTH_CNT + 4;

  logic [WIDTH_TIME-1:0] time_q [S][NUM_PORTS];
  logic [WIDTH_TIME-1:0] time_d [S][NUM_PORTS];
  logic [WIDTH_DATA-1:0] data_q [S][NUM_PORTS];
  logic [WIDTH_DATA-1:0] data_d [S][NUM_PORTS];
  logic                  mode_q, mode_d;
  logic [WIDTH_CNT-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]         nswap, cnt_sum;
  logic [WIDTH_TIME-1:0] tmp_t;
  logic [WIDTH_DATA-1:0] tmp_d;

  function automatic int partner(input int i, input int s);
    return i ^ (1 << (S - 1 - s));
  endfunction

  // Empty slots (time 0) rank last; on an equal key the real flit beats the empty one.
  function automatic logic do_swap(input logic [WIDTH_TIME-1:0] ti,
                                   input logic [WIDTH_TIME-1:0] tj,
                                   input logic m);
    logic [WIDTH_TIME-1:0] ki, kj;
    ki = (ti == '0) ? '1 : ti;
    kj = (tj == '0) ? '1 : tj;
    if (kj < ki) return 1'b1;
    if (ki < kj) return 1'b0;
    if (ti != '0 && tj != '0) return m;
    return (ti == '0) && (tj != '0);
  endfunction

  always_comb begin
    nswap = '0;
    tmp_t = '0;
    tmp_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      time_d[0][i] = in_time[i*WIDTH_TIME +: WIDTH_TIME];
      data_d[0][i] = in_data[i*WIDTH_DATA +: WIDTH_DATA];
    end
    for (int s = 1; s < S; s++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        time_d[s][i] = time_q[s-1][i];
        data_d[s][i] = data_q[s-1][i];
      end
    end
    // Pairs within a stage are disjoint, so swapping in place is safe.
    for (int s = 0; s < S; s++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (partner(i, s) > i) begin
          if (do_swap(time_d[s][i], time_d[s][partner(i, s)], mode_q)) begin
            tmp_t                    = time_d[s][i];
            tmp_d                    = data_d[s][i];
            time_d[s][i]             = time_d[s][partner(i, s)];
            data_d[s][i]             = data_d[s][partner(i, s)];
            time_d[s][partner(i, s)] = tmp_t;
            data_d[s][partner(i, s)] = tmp_d;
            nswap                    = nswap + SW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    mode_d  = stall ? mode_q : ~mode_q;
    cnt_sum = SW'(cnt_q) + nswap;
    if (clr_stats)
      cnt_d = '0;
    else if (stall)
      cnt_d = cnt_q;
    else if (cnt_sum > SW'({WIDTH_CNT{1'b1}}))
      cnt_d = '1;
    else
      cnt_d = cnt_sum[WIDTH_CNT-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q <= '{default: '0};
      data_q <= '{default: '0};
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      if (!stall) begin
        time_q <= time_d;
        data_q <= data_d;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
    assign out_time[p*WIDTH_TIME +: WIDTH_TIME] = time_q[S-1][p];
    assign out_data[p*WIDTH_DATA +: WIDTH_DATA] = data_q[S-1][p];
  end

  assign mode     = mode_q;
  assign swap_cnt = cnt_q;

endmodule

// File: tb/tb_pn_sort_pipe.sv
// Bench for pn_sort_pipe: transaction-level model (sets + step index) vs two DUT widths.
module tb_pn_sort_pipe;
  localparam int N = 4, WT = 8, WD = 32, S = 2;

  logic clk = 1'b0, reset_n = 1'b0, stall = 1'b0, clr_stats = 1'b0;
  logic [N*WT-1:0] in_time = '0;
  logic [N*WD-1:0] in_data = '0;
  logic [N*WT-1:0] out_time, sat_time;
  logic [N*WD-1:0] out_data, sat_data;
  logic            mode, sat_mode;
  logic [15:0]     swap_cnt;
  logic [3:0]      sat_cnt;

  pn_sort_pipe dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .clr_stats(clr_stats),
    .in_time(in_time), .in_data(in_data), .out_time(out_time), .out_data(out_data),
    .mode(mode), .swap_cnt(swap_cnt));

  pn_sort_pipe #(.WIDTH_CNT(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .stall(stall), .clr_stats(clr_stats),
    .in_time(in_time), .in_data(in_data), .out_time(sat_time), .out_data(sat_data),
    .mode(sat_mode), .swap_cnt(sat_cnt));

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;

  // Model: every unstalled step since reset has an index k; a set entering at
  // step k sees mode parity k at stage 0, k+1 at stage 1, and so on.
  logic [N*WT-1:0] hist_t[$];
  logic [N*WD-1:0] hist_d[$];
  logic [N*WT-1:0] exp_t;
  logic [N*WD-1:0] exp_d;
  logic            exp_mode;
  int              exp_cnt, exp_cnt4;

  function automatic void run_net(input logic [N*WT-1:0] it, input logic [N*WD-1:0] id,
                                  input int c0, input int nst,
                                  output logic [N*WT-1:0] ot, output logic [N*WD-1:0] od,
                                  output int sw_last);
    int tm[N];
    logic [WD-1:0] dv[N];
    int ki, kj, j, tt;
    logic [WD-1:0] td;
    bit m, sw;
    for (int p = 0; p < N; p++) begin
      tm[p] = int'(it[p*WT +: WT]);
      dv[p] = id[p*WD +: WD];
    end
    sw_last = 0;
    for (int s = 0; s < nst; s++) begin
      sw_last = 0;
      m = ((c0 + s) % 2) == 1;
      for (int i = 0; i < N; i++) begin
        j = i ^ (1 << (S - 1 - s));
        if (j > i) begin
          ki = (tm[i] == 0) ? 256 : tm[i];
          kj = (tm[j] == 0) ? 256 : tm[j];
          sw = (kj < ki) || (kj == ki && tm[i] != 0 && m);
          if (sw) begin
            tt = tm[i]; tm[i] = tm[j]; tm[j] = tt;
            td = dv[i]; dv[i] = dv[j]; dv[j] = td;
            sw_last++;
          end
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      ot[p*WT +: WT] = WT'(tm[p]);
      od[p*WD +: WD] = dv[p];
    end
  endfunction

  task automatic model_reset();
    hist_t.delete();
    hist_d.delete();
    exp_t = '0; exp_d = '0; exp_mode = 1'b0; exp_cnt = 0; exp_cnt4 = 0;
  endtask

  task automatic model_edge();
    int k, sw, add;
    logic [N*WT-1:0] tt;
    logic [N*WD-1:0] dd;
    add = 0;
    if (!stall) begin
      hist_t.push_back(in_time);
      hist_d.push_back(in_data);
      k = hist_t.size() - 1;
      exp_mode = ~exp_mode;
      if (k >= S - 1) run_net(hist_t[k-S+1], hist_d[k-S+1], k-S+1, S, exp_t, exp_d, sw);
      else begin exp_t = '0; exp_d = '0; end
      for (int s = 0; s < S; s++)
        if (k - s >= 0) begin
          run_net(hist_t[k-s], hist_d[k-s], k-s, s+1, tt, dd, sw);
          add += sw;
        end
    end
    if (clr_stats) begin
      exp_cnt = 0; exp_cnt4 = 0;
    end else if (!stall) begin
      exp_cnt  = (exp_cnt + add > 65535) ? 65535 : exp_cnt + add;
      exp_cnt4 = (exp_cnt4 + add > 15) ? 15 : exp_cnt4 + add;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; clr_stats = 1'b0; in_time = '0; in_data = '0;
    model_reset();
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_time !== '0) begin n_fail++; $display("FAIL reset out_time got %h exp 0", out_time); end
    n_vec++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data got %h exp 0", out_data); end
    n_vec++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reset mode got %b exp 0", mode); end
    n_vec++; if (swap_cnt !== 16'd0) begin n_fail++; $display("FAIL reset swap_cnt got %0d exp 0", swap_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    in_time = {8'd7, 8'd0, 8'd3, 8'd5};
    in_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    cycle();
    in_time = '0; in_data = '0;
    cycle();
    n_vec++; if (out_time !== 32'h00070503) begin n_fail++; $display("FAIL basic out_time got %h exp 00070503", out_time); end
    n_vec++; if (out_data !== {32'hD2, 32'hD3, 32'hD0, 32'hD1}) begin n_fail++; $display("FAIL basic out_data got %h", out_data); end
    n_vec++; if (swap_cnt !== 16'd2) begin n_fail++; $display("FAIL basic swap_cnt got %0d exp 2", swap_cnt); end
    n_vec++; if (out_time !== exp_t || out_data !== exp_d) begin n_fail++; $display("FAIL basic model got %h exp %h", out_time, exp_t); end
  endtask

  task automatic test_tie();
    do_reset();
    in_time = {8'd0, 8'd0, 8'd4, 8'd4};
    in_data = {32'h0, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001};
    cycle();
    in_time = '0; in_data = '0;
    cycle();
    n_vec++; if (out_data !== {64'h0, 32'hAAAA_0001, 32'hBBBB_0002}) begin n_fail++; $display("FAIL tie_mode1 out_data got %h", out_data); end
    do_reset();
    cycle();
    in_time = {8'd0, 8'd0, 8'd4, 8'd4};
    in_data = {32'h0, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001};
    cycle();
    in_time = '0; in_data = '0;
    cycle();
    n_vec++; if (out_data !== {64'h0, 32'hBBBB_0002, 32'hAAAA_0001}) begin n_fail++; $display("FAIL tie_mode0 out_data got %h", out_data); end
  endtask

  task automatic test_empty();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_vec++; if (out_time !== '0) begin n_fail++; $display("FAIL empty out_time got %h exp 0", out_time); end
      n_vec++; if (swap_cnt !== 16'd0) begin n_fail++; $display("FAIL empty swap_cnt got %0d exp 0", swap_cnt); end
      n_vec++; if (mode !== ((i % 2) == 0)) begin n_fail++; $display("FAIL empty mode got %b at %0d", mode, i); end
    end
  endtask

  task automatic test_stall_stream();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      stall = (c >= 2 && c < 5);
      if (c == 0 || c == 1 || c == 5 || c == 6) begin
        for (int p = 0; p < N; p++) in_time[p*WT +: WT] = WT'(((c * 3 + p * 5) % 9) + 1);
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_time = '0; in_data = '0;
      end
      cycle();
      n_vec++; if (out_time !== exp_t || out_data !== exp_d) begin n_fail++; $display("FAIL stall out got %h/%h exp %h/%h", out_time, out_data, exp_t, exp_d); end
      n_vec++; if (mode !== exp_mode) begin n_fail++; $display("FAIL stall mode got %b exp %b", mode, exp_mode); end
      n_vec++; if (swap_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stall swap_cnt got %0d exp %0d", swap_cnt, exp_cnt); end
    end
    stall = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    in_time = {8'd4, 8'd5, 8'd6, 8'd7};
    in_data = {32'h44, 32'h55, 32'h66, 32'h77};
    for (int c = 0; c < 6; c++) begin
      cycle();
      n_vec++; if (sat_cnt !== 4'(exp_cnt4)) begin n_fail++; $display("FAIL sat sat_cnt got %0d exp %0d", sat_cnt, exp_cnt4); end
    end
    n_vec++; if (sat_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold sat_cnt got %0d exp 15", sat_cnt); end
    n_vec++; if (swap_cnt !== 16'd22) begin n_fail++; $display("FAIL sat_wide swap_cnt got %0d exp 22", swap_cnt); end
    stall = 1'b1; clr_stats = 1'b1;
    cycle();
    stall = 1'b0; clr_stats = 1'b0;
    n_vec++; if (sat_cnt !== 4'd0) begin n_fail++; $display("FAIL clr sat_cnt got %0d exp 0", sat_cnt); end
    n_vec++; if (out_time !== exp_t || mode !== exp_mode) begin n_fail++; $display("FAIL clr_hold got %h/%b exp %h/%b", out_time, mode, exp_t, exp_mode); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < N; p++) in_time[p*WT +: WT] = WT'($urandom_range(1, 9));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    in_time = '0; in_data = '0;
    #1;
    n_vec++; if (out_time !== '0 || out_data !== '0) begin n_fail++; $display("FAIL async out got %h/%h exp 0", out_time, out_data); end
    n_vec++; if (mode !== 1'b0 || swap_cnt !== 16'd0) begin n_fail++; $display("FAIL async mode/cnt got %b/%0d exp 0/0", mode, swap_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    in_time = {8'd9, 8'd2, 8'd0, 8'd6};
    in_data = {32'h99, 32'h22, 32'h00, 32'h66};
    cycle();
    in_time = '0; in_data = '0;
    n_vec++; if (out_time !== '0) begin n_fail++; $display("FAIL async_drop out_time got %h exp 0", out_time); end
    cycle();
    n_vec++; if (out_time[7:0] !== 8'd2 || out_data[31:0] !== 32'h22) begin n_fail++; $display("FAIL async_new port0 got %h/%h exp 02/22", out_time[7:0], out_data[31:0]); end
    n_vec++; if (out_time !== exp_t || out_data !== exp_d) begin n_fail++; $display("FAIL async_model got %h exp %h", out_time, exp_t); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < N; p++) begin
        int r;
        r = $urandom_range(0, 9);
        in_time[p*WT +: WT] = (r > 7) ? WT'($urandom_range(1, 254)) : WT'(r);
      end
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      stall     = ($urandom_range(0, 4) == 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      cycle();
      n_vec++; if (out_time !== exp_t) begin n_fail++; $display("FAIL rand out_time got %h exp %h", out_time, exp_t); end
      n_vec++; if (out_data !== exp_d) begin n_fail++; $display("FAIL rand out_data got %h exp %h", out_data, exp_d); end
      n_vec++; if (mode !== exp_mode) begin n_fail++; $display("FAIL rand mode got %b exp %b", mode, exp_mode); end
      n_vec++; if (swap_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand swap_cnt got %0d exp %0d", swap_cnt, exp_cnt); end
      n_vec++; if (sat_cnt !== 4'(exp_cnt4)) begin n_fail++; $display("FAIL rand sat_cnt got %0d exp %0d", sat_cnt, exp_cnt4); end
    end
    stall = 1'b0; clr_stats = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_tie();
    test_empty();
    test_stall_stream();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
